// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - draw/update sequencer for the breakout datapath
// Clears, draws bricks and sprites, waits a frame, then erases sprites and scans bricks for hits.
module frame_sequencer #(
  parameter int NUM_SPRITES  = 2,
  parameter int NUM_BRICKS   = 60,
  parameter int FRAME_CYCLES = 16,
  localparam int IW = $clog2(NUM_BRICKS),
  localparam int SW = $clog2(NUM_SPRITES + 2)
) (
  input  logic                   clock,
  input  logic                   reset_control,
  input  logic                   run_game,
  input  logic                   clear_done,
  input  logic [NUM_SPRITES-1:0] sprite_done,
  input  logic                   brick_valid,
  input  logic                   brick_alive,
  input  logic                   brick_done,
  input  logic                   hit,
  output logic [SW-1:0]          sel_draw,
  output logic                   clear_enable,
  output logic                   sprite_reset_n,
  output logic [NUM_SPRITES-1:0] sprite_enable,
  output logic                   sprite_erase,
  output logic [IW-1:0]          brick_index,
  output logic                   brick_req,
  output logic                   brick_draw,
  output logic                   brick_erase,
  output logic                   brick_delete,
  output logic                   detect_enable,
  output logic                   level_clear,
  output logic [IW:0]            bricks_left
);
  localparam int FW = $clog2(FRAME_CYCLES + 1);
  localparam int LW = IW + 1;
  localparam logic [SW-1:0] SEL_BRICK   = SW'(NUM_SPRITES);
  localparam logic [SW-1:0] SEL_CLEAR   = SW'(NUM_SPRITES + 1);
  localparam logic [SW-1:0] LAST_SPRITE = SW'(NUM_SPRITES - 1);
  localparam logic [IW-1:0] LAST_BRICK  = IW'(NUM_BRICKS - 1);
  localparam logic [FW-1:0] FRAME_LOAD  = FW'(FRAME_CYCLES - 1);
  localparam logic [LW-1:0] FULL_COUNT  = LW'(NUM_BRICKS);

  typedef enum logic [3:0] {
    S_RESET, S_CLEAR, S_BRK_REQ, S_BRK_DRAW, S_BRK_NEXT,
    S_SPR_DRAW, S_FRAME_WAIT, S_SPR_ERASE, S_SCAN_REQ, S_DETECT,
    S_SAMPLE, S_ERASE_BRK, S_DELETE, S_SCAN_NEXT, S_LVL_CLEAR
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] brick_idx;
  logic [SW-1:0] spr_idx;
  logic [FW-1:0] frame_cnt;
  logic [LW-1:0] left;
  logic          spr_done_sel;
  logic          last_brick;
  logic          last_sprite;

  assign last_brick  = (brick_idx == LAST_BRICK);
  assign last_sprite = (spr_idx == LAST_SPRITE);
  assign brick_index = brick_idx;
  assign bricks_left = left;

  // Only the done bit of the currently selected sprite is honoured.
  always_comb begin
    spr_done_sel = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (spr_idx == SW'(i)) spr_done_sel = sprite_done[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_control) begin
      state     <= S_RESET;
      brick_idx <= '0;
      spr_idx   <= '0;
      frame_cnt <= '0;
      left      <= FULL_COUNT;
    end else if (run_game) begin
      state <= state_next;
      case (state)
        S_CLEAR: brick_idx <= '0;
        S_BRK_NEXT, S_SCAN_NEXT: brick_idx <= last_brick ? '0 : brick_idx + 1'b1;
        S_SPR_DRAW, S_SPR_ERASE: begin
          if (spr_done_sel) begin
            spr_idx <= last_sprite ? '0 : spr_idx + 1'b1;
            if (state == S_SPR_DRAW && last_sprite) frame_cnt <= FRAME_LOAD;
          end
        end
        S_FRAME_WAIT: if (frame_cnt != '0) frame_cnt <= frame_cnt - 1'b1;
        S_DELETE: if (left != '0) left <= left - 1'b1;
        S_LVL_CLEAR: left <= FULL_COUNT;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:      state_next = S_CLEAR;
      S_CLEAR:      if (clear_done) state_next = S_BRK_REQ;
      S_BRK_REQ:    if (brick_valid) state_next = brick_alive ? S_BRK_DRAW : S_BRK_NEXT;
      S_BRK_DRAW:   if (brick_done) state_next = S_BRK_NEXT;
      S_BRK_NEXT:   state_next = last_brick ? S_SPR_DRAW : S_BRK_REQ;
      S_SPR_DRAW:   if (spr_done_sel && last_sprite) state_next = S_FRAME_WAIT;
      S_FRAME_WAIT: if (frame_cnt == '0) state_next = S_SPR_ERASE;
      S_SPR_ERASE:  if (spr_done_sel && last_sprite) state_next = S_SCAN_REQ;
      S_SCAN_REQ:   if (brick_valid) state_next = brick_alive ? S_DETECT : S_SCAN_NEXT;
      S_DETECT:     state_next = S_SAMPLE;
      S_SAMPLE:     state_next = hit ? S_ERASE_BRK : S_SCAN_NEXT;
      S_ERASE_BRK:  if (brick_done) state_next = S_DELETE;
      S_DELETE:     state_next = S_SCAN_NEXT;
      S_SCAN_NEXT: begin
        if (!last_brick)     state_next = S_SCAN_REQ;
        else if (left == '0) state_next = S_LVL_CLEAR;
        else                 state_next = S_SPR_DRAW;
      end
      S_LVL_CLEAR:  state_next = S_CLEAR;
      default:      state_next = S_RESET;
    endcase
  end

  always_comb begin
    sel_draw       = SEL_CLEAR;
    clear_enable   = 1'b0;
    sprite_reset_n = 1'b1;
    sprite_enable  = '0;
    sprite_erase   = 1'b0;
    brick_req      = 1'b0;
    brick_draw     = 1'b0;
    brick_erase    = 1'b0;
    brick_delete   = 1'b0;
    detect_enable  = 1'b0;
    level_clear    = 1'b0;
    case (state)
      S_RESET: sprite_reset_n = 1'b0;
      S_CLEAR: clear_enable = 1'b1;
      S_BRK_REQ, S_SCAN_REQ: begin
        brick_req = 1'b1;
        sel_draw  = SEL_BRICK;
      end
      S_BRK_DRAW: begin
        brick_draw = 1'b1;
        sel_draw   = SEL_BRICK;
      end
      S_SPR_DRAW, S_SPR_ERASE: begin
        sel_draw     = spr_idx;
        sprite_erase = (state == S_SPR_ERASE);
        for (int i = 0; i < NUM_SPRITES; i++) sprite_enable[i] = (spr_idx == SW'(i));
      end
      S_DETECT: detect_enable = 1'b1;
      S_ERASE_BRK: begin
        brick_erase = 1'b1;
        sel_draw    = SEL_BRICK;
      end
      S_DELETE: brick_delete = 1'b1;
      S_LVL_CLEAR: begin
        level_clear    = 1'b1;
        sprite_reset_n = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - testbench for frame_sequencer
module tb_frame_sequencer;
  localparam int NS = 2;
  localparam int NB = 60;
  localparam int FC = 16;
  localparam int IW = 6;
  localparam int SW = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_control, run_game, clear_done, brick_valid, brick_alive, brick_done, hit;
  logic [NS-1:0] sprite_done;
  logic [SW-1:0] sel_draw;
  logic clear_enable, sprite_reset_n, sprite_erase;
  logic [NS-1:0] sprite_enable;
  logic [IW-1:0] brick_index;
  logic brick_req, brick_draw, brick_erase, brick_delete, detect_enable, level_clear;
  logic [IW:0] bricks_left;

  frame_sequencer #(.NUM_SPRITES(NS), .NUM_BRICKS(NB), .FRAME_CYCLES(FC)) dut (
    .clock(clock), .reset_control(reset_control), .run_game(run_game),
    .clear_done(clear_done), .sprite_done(sprite_done), .brick_valid(brick_valid),
    .brick_alive(brick_alive), .brick_done(brick_done), .hit(hit),
    .sel_draw(sel_draw), .clear_enable(clear_enable), .sprite_reset_n(sprite_reset_n),
    .sprite_enable(sprite_enable), .sprite_erase(sprite_erase), .brick_index(brick_index),
    .brick_req(brick_req), .brick_draw(brick_draw), .brick_erase(brick_erase),
    .brick_delete(brick_delete), .detect_enable(detect_enable), .level_clear(level_clear),
    .bricks_left(bricks_left)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit alive[NB];
  bit hit_map[NB];
  bit drawn[NB];
  bit env_on = 0;

  int exp_idx = 0, exp_spr = 0, exp_left = NB;
  int bursts = 0, detects = 0, exp_det = 0, fw_cnt = 0;
  int scans_done = 0, draws_done = 0, lvl_count = 0;
  bit in_draw = 0, in_scan = 0, fw_active = 0, prev_draw = 0;

  int c_clr = -1, c_brk = -1, c_bd = -1, c_spr = -1;
  bit prev_det = 0;
  int prev_idx = 0;

  typedef struct {
    logic rst, run, cdone, bvalid;
    logic cen, srn, breq;
    int   sel, idx, left;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_alive();
    int n = 0;
    for (int i = 0; i < NB; i++) n += int'(alive[i]);
    return n;
  endfunction

  function automatic bit step(input bit req, inout int c, input int maxlat);
    if (!req) begin
      c = -1;
      return 1'b0;
    end
    if (c < 0) c = $urandom_range(0, maxlat);
    if (c == 0) begin
      c = -1;
      return 1'b1;
    end
    c--;
    return 1'b0;
  endfunction

  // Environment: clear engine, brick storage, draw engines, sprites, collision detector.
  initial begin
    bit sd;
    forever begin
      @(negedge clock);
      if (env_on && run_game && reset_control) begin
        clear_done  = step(clear_enable, c_clr, 5);
        brick_valid = step(brick_req, c_brk, 2);
        brick_alive = brick_valid ? alive[brick_index] : 1'($urandom);
        brick_done  = step(brick_draw || brick_erase, c_bd, 3);
        sd = step(sprite_enable != '0, c_spr, 3);
        sprite_done = NS'($urandom);
        for (int i = 0; i < NS; i++) if (sprite_enable[i]) sprite_done[i] = sd;
        hit      = prev_det && hit_map[prev_idx];
        prev_det = detect_enable;
        prev_idx = int'(brick_index);
      end
    end
  end

  // Scoreboard, evaluated once per advancing cycle.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!reset_control) begin
        exp_idx = 0; exp_spr = 0; exp_left = NB;
        fw_active = 0; in_scan = 0; in_draw = 0; prev_draw = 0;
      end else if (run_game) begin
        if (clear_enable) begin
          check("clear_sel", sel_draw, NS + 1);
          if (!in_draw) begin
            check("left_at_clear", bricks_left, exp_left);
            in_draw = 1; bursts = 0;
            for (int i = 0; i < NB; i++) drawn[i] = 0;
          end
        end
        if (brick_req || brick_erase) check("brick_sel", sel_draw, NS);
        if (brick_req && brick_valid) begin
          check("brick_index_order", brick_index, exp_idx);
          exp_idx = (exp_idx + 1) % NB;
        end
        if (brick_draw && !prev_draw) begin
          bursts++;
          drawn[brick_index] = 1;
        end
        prev_draw = brick_draw;
        if (detect_enable) begin
          check("detect_on_live_brick", alive[brick_index], 1);
          detects++;
        end
        if (brick_delete) begin
          check("delete_on_hit_brick", hit_map[brick_index] && alive[brick_index], 1);
          check("left_before_delete", bricks_left, exp_left);
          alive[brick_index] = 0;
          if (exp_left > 0) exp_left--;
        end
        if (in_draw && sprite_enable != '0 && !sprite_erase) begin
          int m = 0;
          for (int i = 0; i < NB; i++) if (drawn[i] != alive[i]) m++;
          check("draw_bursts", bursts, count_alive());
          check("drawn_set_mismatches", m, 0);
          in_draw = 0;
          draws_done++;
        end
        if (sprite_enable != '0) begin
          check("sprite_onehot", sprite_enable, 1 << exp_spr);
          check("sprite_sel", sel_draw, exp_spr);
        end
        if (sprite_enable[NS-1] && !sprite_erase && sprite_done[NS-1]) begin
          fw_active = 1; fw_cnt = 0;
        end else if (fw_active) begin
          if (sprite_enable == '0) fw_cnt++;
          else begin
            check("frame_wait_cycles", fw_cnt, FC);
            check("erase_after_wait", sprite_erase, 1);
            fw_active = 0;
          end
        end
        if (sprite_enable != '0 && sprite_done[exp_spr]) exp_spr = (exp_spr + 1) % NS;
        if (sprite_enable != '0 && sprite_erase && !in_scan) begin
          in_scan = 1; detects = 0; exp_det = count_alive();
        end
        if (in_scan && (level_clear || (sprite_enable != '0 && !sprite_erase))) begin
          check("scan_detects", detects, exp_det);
          check("level_clear_iff_empty", level_clear, int'(exp_left == 0));
          in_scan = 0;
          scans_done++;
        end
        if (level_clear) begin
          check("left_zero_at_level_clear", bricks_left, 0);
          check("index_wrapped_at_level_clear", brick_index, 0);
          check("sprite_reset_at_level_clear", sprite_reset_n, 0);
          lvl_count++;
          for (int i = 0; i < NB; i++) alive[i] = 1;
          exp_left = NB;
        end
      end
    end
  end

  task automatic wait_scans(input int n);
    int t = 0;
    while (scans_done < n && t < 20000) begin
      @(negedge clock);
      t++;
    end
    check($sformatf("scan%0d_completed", n), int'(scans_done >= n), 1);
  endtask

  initial begin
    int t;
    reset_control = 0; run_game = 1; clear_done = 0; brick_valid = 0; brick_alive = 1;
    brick_done = 0; hit = 0; sprite_done = '0;
    for (int i = 0; i < NB; i++) begin alive[i] = 1; hit_map[i] = 0; end

    //            rst  run  cdone bvld  cen  srn  breq sel idx left
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 60};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 60};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0, 60};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0, 60};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0, 60};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 60};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 0, 60};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 60};

    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      reset_control = tbl[i].rst; run_game = tbl[i].run;
      clear_done = tbl[i].cdone; brick_valid = tbl[i].bvalid;
      @(negedge clock);
      check($sformatf("vec%0d_clear_enable", i), clear_enable, tbl[i].cen);
      check($sformatf("vec%0d_sprite_reset_n", i), sprite_reset_n, tbl[i].srn);
      check($sformatf("vec%0d_brick_req", i), brick_req, tbl[i].breq);
      check($sformatf("vec%0d_sel_draw", i), sel_draw, tbl[i].sel);
      check($sformatf("vec%0d_brick_index", i), brick_index, tbl[i].idx);
      check($sformatf("vec%0d_bricks_left", i), bricks_left, tbl[i].left);
    end
    clear_done = 0; brick_valid = 0;
    env_on = 1;

    hit_map[3] = 1; hit_map[59] = 1;
    t = 0;
    while (!fw_active && t < 20000) begin @(negedge clock); t++; end
    check("frame_wait_reached", int'(fw_active), 1);
    repeat (3) @(negedge clock);
    run_game = 0;
    repeat (10) @(negedge clock);
    check("paused_no_sprite", sprite_enable, 0);
    run_game = 1;
    wait_scans(1);
    check("left_after_two_hits", bricks_left, 58);
    check("first_draw_pass", draws_done, 1);

    for (int s = 2; s <= 4; s++) begin
      for (int i = 0; i < NB; i++) hit_map[i] = (i != 7) && ($urandom_range(0, 3) == 0);
      wait_scans(s);
      check($sformatf("left_after_scan%0d", s), bricks_left, count_alive());
    end

    for (int i = 0; i < NB; i++) hit_map[i] = (i != 7);
    wait_scans(5);
    check("one_brick_left", bricks_left, 1);
    check("brick7_alive", alive[7], 1);

    for (int i = 0; i < NB; i++) hit_map[i] = (i == 7);
    wait_scans(6);
    check("level_clear_count", lvl_count, 1);
    t = 0;
    while (!clear_enable && t < 200) begin @(negedge clock); t++; end
    check("clear_after_level", clear_enable, 1);
    check("left_reloaded", bricks_left, NB);

    for (int i = 0; i < NB; i++) hit_map[i] = ($urandom_range(0, 2) == 0);
    t = 0;
    while (!brick_erase && t < 20000) begin @(negedge clock); t++; end
    check("erase_reached", brick_erase, 1);
    reset_control = 0;
    env_on = 0;
    @(negedge clock);
    check("reset_sprite_reset_n", sprite_reset_n, 0);
    check("reset_brick_erase", brick_erase, 0);
    check("reset_bricks_left", bricks_left, NB);
    check("reset_brick_index", brick_index, 0);
    check("reset_sel_draw", sel_draw, NS + 1);
    reset_control = 1;
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
